// File: rtl/ic_jpeg_pkg.sv
// Shared definitions for the JPEG-path buffering blocks: FIFO read modes,
// the per-cycle access classification and a constant-safe ceil(log2).
package ic_jpeg_pkg;

    localparam int FF_NORMAL    = 0;
    localparam int FF_SHOWAHEAD = 1;

    // Accepted accesses in one cycle, packed as {write, read}
    typedef enum logic [1:0] {
        ACC_IDLE = 2'b00,
        ACC_RD   = 2'b01,
        ACC_WR   = 2'b10,
        ACC_RW   = 2'b11
    } acc_e;

    // ceil(log2(value)); usable in parameter expressions
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ic_jpeg_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read-during-write to the same address returns the old contents; the FIFO
// never relies on that case and handles its own bypass.
module ic_jpeg_sdp_ram #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Write port
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port
    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/ic_jpeg_sync_fifo.sv
// Parametrised single-clock FIFO between the colour-conversion stage and the
// DCT/packing stages. Storage sits in an inferable dual-port RAM; the fill
// counter, status flags and the output word register live here.
//
// Normal mode: an accepted read fetches the head word from RAM on the
// accepting edge and transfers it to q on the following edge.
// Show-ahead mode: the RAM is re-read every cycle at the next head address;
// a word written straight into the head slot is captured in r_q instead,
// because the RAM read port would return the stale contents that cycle.
module ic_jpeg_sync_fifo
    import ic_jpeg_pkg::*;
#(
    parameter  int WIDTH     = 64,
    parameter  int DEPTH     = 16,
    parameter  int SHOWAHEAD = FF_NORMAL,
    parameter  int AF_LEVEL  = DEPTH - 2,
    parameter  int AE_LEVEL  = 2,
    localparam int UW        = clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             sclr,
    input  logic [WIDTH-1:0] data,
    input  logic             wrreq,
    input  logic             rdreq,
    output logic [WIDTH-1:0] q,
    output logic             empty,
    output logic             full,
    output logic [UW-1:0]    usedw,
    output logic             almost_empty,
    output logic             almost_full,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = clog2(DEPTH);

    if (DEPTH < 4 || DEPTH > 1024 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
        $error("ic_jpeg_sync_fifo: DEPTH must be a power of two in 4..1024");
    end
    if (WIDTH < 1 || WIDTH > 256) begin : g_chk_width
        $error("ic_jpeg_sync_fifo: WIDTH must be in 1..256");
    end
    if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_chk_levels
        $error("ic_jpeg_sync_fifo: thresholds need AE_LEVEL < AF_LEVEL <= DEPTH");
    end
    if (SHOWAHEAD != FF_NORMAL && SHOWAHEAD != FF_SHOWAHEAD) begin : g_chk_mode
        $error("ic_jpeg_sync_fifo: SHOWAHEAD must be 0 or 1");
    end

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [UW-1:0]    r_usedw;
    logic             r_empty;
    logic             r_full;
    logic             r_almost_empty;
    logic             r_almost_full;
    logic             r_overflow;
    logic             r_underflow;
    logic [WIDTH-1:0] r_q;
    logic             r_use_ram;
    logic             r_rd_pend;

    logic             w_wr_acc;
    logic             w_rd_acc;
    acc_e             w_acc;
    logic [AW-1:0]    w_wr_ptr_nxt;
    logic [AW-1:0]    w_rd_ptr_nxt;
    logic [UW-1:0]    w_usedw_nxt;
    logic             w_ram_we;
    logic             w_ram_re;
    logic [AW-1:0]    w_ram_raddr;
    logic [WIDTH-1:0] w_ram_q;
    logic             w_byp;
    logic [WIDTH-1:0] w_q;

    ic_jpeg_sdp_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk     (clock),
        .i_wr_en   (w_ram_we),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data),
        .i_rd_en   (w_ram_re),
        .i_rd_addr (w_ram_raddr),
        .o_rd_data (w_ram_q)
    );

    // Access acceptance, next pointers/fill level and RAM read steering
    always_comb begin
        w_wr_acc     = wrreq & ~r_full;
        w_rd_acc     = rdreq & ~r_empty;
        w_acc        = acc_e'({w_wr_acc, w_rd_acc});
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_usedw_nxt  = r_usedw;

        if (sclr) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_usedw_nxt  = '0;
        end else begin
            if (w_wr_acc) begin
                w_wr_ptr_nxt = r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                w_rd_ptr_nxt = r_rd_ptr + AW'(1);
            end
            case (w_acc)
                ACC_WR:  w_usedw_nxt = r_usedw + UW'(1);
                ACC_RD:  w_usedw_nxt = r_usedw - UW'(1);
                default: w_usedw_nxt = r_usedw;
            endcase
        end

        w_ram_we = w_wr_acc & ~sclr;
        // The written word becomes the head after this edge
        w_byp    = w_ram_we & (r_wr_ptr == w_rd_ptr_nxt);

        if (SHOWAHEAD == FF_SHOWAHEAD) begin
            w_ram_re    = 1'b1;
            w_ram_raddr = w_rd_ptr_nxt;
        end else begin
            w_ram_re    = w_rd_acc & ~sclr;
            w_ram_raddr = r_rd_ptr;
        end

        w_q = r_use_ram ? w_ram_q : r_q;
    end

    // Pointers, fill level and status flags, all derived from the next fill level
    always_ff @(posedge clock) begin
        r_wr_ptr       <= w_wr_ptr_nxt;
        r_rd_ptr       <= w_rd_ptr_nxt;
        r_usedw        <= w_usedw_nxt;
        r_empty        <= (w_usedw_nxt == '0);
        r_full         <= (w_usedw_nxt == UW'(DEPTH));
        r_almost_empty <= (w_usedw_nxt < UW'(AE_LEVEL));
        r_almost_full  <= (w_usedw_nxt >= UW'(AF_LEVEL));
    end

    // Sticky protocol-error flags; only sclr clears them
    always_ff @(posedge clock) begin
        if (sclr) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wrreq && r_full) begin
                r_overflow <= 1'b1;
            end
            if (rdreq && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Output word: delayed RAM capture (normal) or head tracking (show-ahead)
    always_ff @(posedge clock) begin
        if (sclr) begin
            r_q       <= '0;
            r_use_ram <= 1'b0;
            r_rd_pend <= 1'b0;
        end else if (SHOWAHEAD == FF_SHOWAHEAD) begin
            r_rd_pend <= 1'b0;
            if (w_byp) begin
                r_q       <= data;
                r_use_ram <= 1'b0;
            end else if (w_usedw_nxt != '0) begin
                r_use_ram <= 1'b1;
            end else begin
                // Going or staying empty: freeze whatever is on q now
                r_q       <= w_q;
                r_use_ram <= 1'b0;
            end
        end else begin
            r_use_ram <= 1'b0;
            r_rd_pend <= w_rd_acc;
            if (r_rd_pend) begin
                r_q <= w_ram_q;
            end
        end
    end

    assign q            = w_q;
    assign empty        = r_empty;
    assign full         = r_full;
    assign usedw        = r_usedw;
    assign almost_empty = r_almost_empty;
    assign almost_full  = r_almost_full;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_ic_jpeg_sync_fifo.sv
// Bench for ic_jpeg_sync_fifo: one normal-mode and one show-ahead instance
// (64x16, AF=14, AE=2) share the same stimulus. The driver updates a queue
// model on each rising edge and pushes expected normal-mode read words into
// a scoreboard; a monitor pops them when due and checks both instances on
// every falling edge.
module tb_ic_jpeg_sync_fifo;

    logic        clock = 1'b0;
    logic        sclr  = 1'b0;
    logic [63:0] data  = '0;
    logic        wrreq = 1'b0;
    logic        rdreq = 1'b0;

    logic [63:0] n_q, s_q;
    logic        n_empty, n_full, n_ae, n_af, n_ovf, n_unf;
    logic        s_empty, s_full, s_ae, s_af, s_ovf, s_unf;
    logic [4:0]  n_usedw, s_usedw;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [63:0] w;
        int          due;
    } sb_t;

    logic [63:0] m_q[$];
    sb_t         sb[$];
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;
    logic [63:0] sa_exp = '0;
    logic [63:0] norm_exp = '0;
    int          edge_cnt = 0;
    logic        mon_en = 1'b0;

    always #5 clock = ~clock;

    ic_jpeg_sync_fifo #(
        .WIDTH(64), .DEPTH(16), .SHOWAHEAD(0), .AF_LEVEL(14), .AE_LEVEL(2)
    ) u_norm (
        .clock(clock), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
        .q(n_q), .empty(n_empty), .full(n_full), .usedw(n_usedw),
        .almost_empty(n_ae), .almost_full(n_af),
        .overflow(n_ovf), .underflow(n_unf)
    );

    ic_jpeg_sync_fifo #(
        .WIDTH(64), .DEPTH(16), .SHOWAHEAD(1), .AF_LEVEL(14), .AE_LEVEL(2)
    ) u_sa (
        .clock(clock), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
        .q(s_q), .empty(s_empty), .full(s_full), .usedw(s_usedw),
        .almost_empty(s_ae), .almost_full(s_af),
        .overflow(s_ovf), .underflow(s_unf)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour of one rising edge with the given requests
    task automatic model_edge(input logic w, input logic r, input logic [63:0] d, input logic c);
        bit wa, ra;
        edge_cnt++;
        if (c) begin
            m_q.delete();
            sb.delete();
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
            sa_exp   = '0;
            norm_exp = '0;
            mon_en   = 1'b1;
        end else begin
            wa = w && (m_q.size() < 16);
            ra = r && (m_q.size() > 0);
            if (w && !wa) m_ovf = 1'b1;
            if (r && !ra) m_unf = 1'b1;
            if (ra) begin
                sb.push_back('{w: m_q[0], due: edge_cnt + 1});
                void'(m_q.pop_front());
            end
            if (wa) m_q.push_back(d);
            if (m_q.size() > 0) sa_exp = m_q[0];
        end
    endtask

    task automatic step(input logic w, input logic r, input logic [63:0] d, input logic c);
        wrreq = w;
        rdreq = r;
        data  = d;
        sclr  = c;
        @(posedge clock);
        model_edge(w, r, d, c);
        @(negedge clock);
    endtask

    // Monitor: retire due scoreboard entries, then check both instances
    always @(negedge clock) begin
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].due <= edge_cnt) begin
                norm_exp = sb.pop_front().w;
            end
            chk("norm.q",        n_q,               norm_exp);
            chk("norm.usedw",    64'(n_usedw),      64'(m_q.size()));
            chk("norm.empty",    64'(n_empty),      64'(m_q.size() == 0));
            chk("norm.full",     64'(n_full),       64'(m_q.size() == 16));
            chk("norm.almost_e", 64'(n_ae),         64'(m_q.size() < 2));
            chk("norm.almost_f", 64'(n_af),         64'(m_q.size() >= 14));
            chk("norm.overflow", 64'(n_ovf),        64'(m_ovf));
            chk("norm.underflow",64'(n_unf),        64'(m_unf));
            chk("sa.q",          s_q,               sa_exp);
            chk("sa.usedw",      64'(s_usedw),      64'(m_q.size()));
            chk("sa.empty",      64'(s_empty),      64'(m_q.size() == 0));
            chk("sa.full",       64'(s_full),       64'(m_q.size() == 16));
            chk("sa.almost_e",   64'(s_ae),         64'(m_q.size() < 2));
            chk("sa.almost_f",   64'(s_af),         64'(m_q.size() >= 14));
            chk("sa.overflow",   64'(s_ovf),        64'(m_ovf));
            chk("sa.underflow",  64'(s_unf),        64'(m_unf));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clock);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Fill with 0x0..0xF, then one write too many
        for (int i = 0; i < 16; i++) step(1, 0, 64'(i), 0);
        chk("fill_full",  64'(n_full),  64'd1);
        chk("fill_usedw", 64'(n_usedw), 64'd16);
        step(1, 0, 64'h99, 0);
        chk("ovf_set",    64'(n_ovf),   64'd1);
        chk("ovf_usedw",  64'(n_usedw), 64'd16);

        // Drain, let the last word land, then read while empty
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("drain_empty", 64'(n_empty), 64'd1);
        chk("drain_lastq", n_q,          64'hF);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("unf_set",     64'(n_unf),   64'd1);
        chk("unf_q_hold",  n_q,          64'hF);

        // Show-ahead: word appears without a read, holds after draining
        step(0, 0, 0, 1);
        step(1, 0, 64'hAA, 0);
        chk("sa_q_aa",     s_q,          64'hAA);
        chk("sa_nonempty", 64'(s_empty), 64'd0);
        step(0, 1, 0, 0);
        chk("sa_empty",    64'(s_empty), 64'd1);
        chk("sa_q_hold",   s_q,          64'hAA);

        // Fill to 8, then 100 cycles of simultaneous read+write across wrap
        for (int i = 0; i < 8; i++) step(1, 0, 64'h100 + 64'(i), 0);
        for (int i = 0; i < 100; i++) step(1, 1, 64'h200 + 64'(i), 0);
        chk("rw_usedw8",   64'(n_usedw), 64'd8);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("rw_lastq",    n_q,          64'h200 + 64'd99);

        // Threshold walk 0 -> 16
        for (int i = 1; i <= 16; i++) begin
            step(1, 0, 64'h300 + 64'(i), 0);
            if (i == 1)  chk("ae_at1",  64'(n_ae), 64'd1);
            if (i == 2)  chk("ae_at2",  64'(n_ae), 64'd0);
            if (i == 13) chk("af_at13", 64'(n_af), 64'd0);
            if (i == 14) chk("af_at14", 64'(n_af), 64'd1);
        end
        // Read+write while full: write rejected, read proceeds
        step(1, 1, 64'h3FF, 0);
        chk("full_rw_usedw", 64'(n_usedw), 64'd15);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
        chk("pre_clr_usedw", 64'(n_usedw), 64'd9);

        // Clear mid-operation
        step(0, 0, 0, 1);
        chk("clr_usedw",  64'(n_usedw), 64'd0);
        chk("clr_empty",  64'(n_empty), 64'd1);
        chk("clr_q",      n_q,          64'd0);
        chk("clr_sa_q",   s_q,          64'd0);
        chk("clr_ovf",    64'(n_ovf),   64'd0);

        // Resume after clear
        step(1, 0, 64'h55, 0);
        step(1, 0, 64'h66, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("resume_q55", n_q, 64'h55);
        step(0, 0, 0, 0);
        chk("resume_q66", n_q, 64'h66);

        // Read+write while empty: read rejected, write accepted
        step(1, 1, 64'h77, 0);
        chk("empty_rw_usedw", 64'(n_usedw), 64'd1);
        chk("empty_rw_unf",   64'(n_unf),   64'd1);
        // Read+write at one word: new word becomes head immediately
        for (int i = 0; i < 5; i++) step(1, 1, 64'h400 + 64'(i), 0);
        chk("one_rw_sa_q", s_q, 64'h404);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("one_rw_norm_q", n_q, 64'h404);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
